// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the mm:ss BCD countdown timer.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned ONES_MAX = 9;

  // Nibble offsets inside the packed {m_tens, m_ones, s_tens, s_ones} word.
  localparam int unsigned S_ONES_LSB = 0;
  localparam int unsigned S_TENS_LSB = 4;
  localparam int unsigned M_ONES_LSB = 8;
  localparam int unsigned M_TENS_LSB = 12;

endpackage

// File: rtl/countdown_timer_digit.sv
// One BCD down-counting digit with saturating load and borrow output.
module bcd_down_digit
  import countdown_timer_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  output logic [DIGIT_W-1:0] digit,
  output logic               borrow_out
);

  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX);
  localparam logic [DIGIT_W-1:0] ONE_D = DIGIT_W'(1);

  // Borrow ripples combinationally so the whole chain settles in one cycle.
  assign borrow_out = en && (digit == '0);

  // Load clamps to MAX; decrement wraps 0 -> MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= '0;
    end else if (ld) begin
      digit <= (ld_val > MAX_D) ? MAX_D : ld_val;
    end else if (en) begin
      digit <= (digit == '0) ? MAX_D : digit - ONE_D;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable mm:ss BCD countdown timer with run/pause control and expiry pulse.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned SEC_TENS_MAX = 5,
  parameter int unsigned MIN_TENS_MAX = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] cnt,
  output logic        running,
  output logic        done
);

  state_t state, state_n;
  logic   done_n;
  logic   ld, dec, is_zero, expiring;
  logic   b_s_ones, b_s_tens, b_m_ones;
  logic   unused_borrow;

  assign is_zero  = (cnt == '0);
  assign expiring = (cnt == 16'h0001);
  assign ld       = load && (state != RUN);
  assign dec      = (state == RUN) && tick && !stop && !is_zero;

  bcd_down_digit #(.MAX(ONES_MAX)) u_s_ones (
    .clk(clk), .rst(rst), .en(dec), .ld(ld),
    .ld_val(load_val[S_ONES_LSB +: DIGIT_W]),
    .digit(cnt[S_ONES_LSB +: DIGIT_W]), .borrow_out(b_s_ones)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_s_tens (
    .clk(clk), .rst(rst), .en(b_s_ones), .ld(ld),
    .ld_val(load_val[S_TENS_LSB +: DIGIT_W]),
    .digit(cnt[S_TENS_LSB +: DIGIT_W]), .borrow_out(b_s_tens)
  );

  bcd_down_digit #(.MAX(ONES_MAX)) u_m_ones (
    .clk(clk), .rst(rst), .en(b_s_tens), .ld(ld),
    .ld_val(load_val[M_ONES_LSB +: DIGIT_W]),
    .digit(cnt[M_ONES_LSB +: DIGIT_W]), .borrow_out(b_m_ones)
  );

  // Borrow out of the top digit would mean underflow, which dec gating prevents.
  bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_m_tens (
    .clk(clk), .rst(rst), .en(b_m_ones), .ld(ld),
    .ld_val(load_val[M_TENS_LSB +: DIGIT_W]),
    .digit(cnt[M_TENS_LSB +: DIGIT_W]), .borrow_out(unused_borrow)
  );

  // Next-state and expiry pulse; load beats start, stop beats start and tick.
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    unique case (state)
      IDLE, PAUSE: begin
        if (load) begin
          state_n = IDLE;
        end else if (start && !stop && !is_zero) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = PAUSE;
        end else if (dec && expiring) begin
          state_n = EXPIRED;
          done_n  = 1'b1;
        end
      end
      EXPIRED: begin
        if (load) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      running <= (state_n == RUN);
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        rst, tick, load, start, stop;
  logic [15:0] load_val;
  logic [15:0] cnt;
  logic        running, done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  countdown_timer #(.SEC_TENS_MAX(5), .MIN_TENS_MAX(5)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .cnt(cnt), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Apply the currently driven pulses for one edge, then release them.
  task automatic step();
    @(posedge clk);
    #1;
    rst = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v; step();
  endtask

  task automatic expect_out(input string tag, input logic [15:0] c, input logic r, input logic d);
    check({tag, ".cnt"}, cnt, c);
    check({tag, ".running"}, {15'd0, running}, {15'd0, r});
    check({tag, ".done"}, {15'd0, done}, {15'd0, d});
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; load_val = '0;
    step();
    expect_out("reset", 16'h0000, 1'b0, 1'b0);

    // Count 3 -> 0 and expire.
    do_load(16'h0003);
    expect_out("ld3", 16'h0003, 1'b0, 1'b0);
    start = 1'b1; step();
    expect_out("start3", 16'h0003, 1'b1, 1'b0);
    tick = 1'b1; step(); expect_out("t1", 16'h0002, 1'b1, 1'b0);
    tick = 1'b1; step(); expect_out("t2", 16'h0001, 1'b1, 1'b0);
    tick = 1'b1; step(); expect_out("t3", 16'h0000, 1'b0, 1'b1);
    step();              expect_out("post_exp", 16'h0000, 1'b0, 1'b0);

    // Full borrow chain 10:00 -> 09:59.
    do_load(16'h1000);
    start = 1'b1; step();
    tick = 1'b1; step(); expect_out("borrow", 16'h0959, 1'b1, 1'b0);

    // Load in RUN is ignored.
    do_load(16'h0011);
    expect_out("ld_in_run", 16'h0959, 1'b1, 1'b0);
    stop = 1'b1; step();
    expect_out("stop", 16'h0959, 1'b0, 1'b0);

    // Pause / resume.
    do_load(16'h0105);
    start = 1'b1; step();
    tick = 1'b1; step();              expect_out("p_t1", 16'h0104, 1'b1, 1'b0);
    tick = 1'b1; stop = 1'b1; step(); expect_out("p_stoptick", 16'h0104, 1'b0, 1'b0);
    tick = 1'b1; step();              expect_out("p_paused", 16'h0104, 1'b0, 1'b0);
    start = 1'b1; step();             expect_out("p_resume", 16'h0104, 1'b1, 1'b0);
    tick = 1'b1; step();              expect_out("p_t2", 16'h0103, 1'b1, 1'b0);

    // Held tick decrements every cycle, with s_tens borrow.
    stop = 1'b1; step();
    do_load(16'h0110);
    start = 1'b1; step();
    tick = 1'b1; step(); tick = 1'b1; step(); tick = 1'b1; step();
    expect_out("held", 16'h0107, 1'b1, 1'b0);
    stop = 1'b1; step();

    // Load clamping.
    do_load(16'hFFFF); expect_out("clampF", 16'h5959, 1'b0, 1'b0);
    do_load(16'h7C3D); check("clamp_mix", cnt, 16'h5939);
    do_load(16'h0A08); check("clamp_mo", cnt, 16'h0908);

    // Start with zero count after reset is ignored.
    rst = 1'b1; step();
    start = 1'b1; step();
    expect_out("start_zero", 16'h0000, 1'b0, 1'b0);

    // Reset mid-RUN, then load+start together.
    do_load(16'h0042);
    start = 1'b1; step();
    tick = 1'b1; step(); expect_out("r_t", 16'h0041, 1'b1, 1'b0);
    rst = 1'b1; tick = 1'b1; step();
    expect_out("rst_run", 16'h0000, 1'b0, 1'b0);
    load = 1'b1; load_val = 16'h0042; start = 1'b1; step();
    expect_out("ld_start", 16'h0042, 1'b0, 1'b0);
    step();
    check("ld_start_idle", {15'd0, running}, 16'h0000);

    // Expire, then ticks/start in EXPIRED do nothing; reload and expire again.
    do_load(16'h0001);
    start = 1'b1; step();
    tick = 1'b1; step(); expect_out("e1", 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; start = (i == 1); step();
      expect_out("e_hold", 16'h0000, 1'b0, 1'b0);
    end
    do_load(16'h0001);
    expect_out("e_reload", 16'h0001, 1'b0, 1'b0);
    start = 1'b1; step();
    tick = 1'b1; step(); expect_out("e2", 16'h0000, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
